// File: rtl/rsa_xcel_mont_pkg.sv
// Shared types and constants for the Montgomery-domain conversion blocks.
package rsa_xcel_mont_pkg;

   localparam int unsigned NBITS_DFLT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rsa_xcel_mont_DblRed.sv
// One doubling-reduce step: r_out = (2*r_in) mod n, given r_in < n.
module rsa_xcel_mont_DblRed #(
   parameter int unsigned NBITS = 32
) (
   input  logic [NBITS-1:0] r_in,
   input  logic [NBITS-1:0] n,
   output logic [NBITS-1:0] r_out
);

   logic [NBITS:0] t;
   logic [NBITS:0] n_ext;

   // Compare on the full NBITS+1 bits so the shifted-out carry is kept.
   always_comb begin
      t     = {r_in, 1'b0};
      n_ext = {1'b0, n};
      if (t >= n_ext) r_out = NBITS'(t - n_ext);
      else            r_out = t[NBITS-1:0];
   end

endmodule

// File: rtl/rsa_xcel_mont_to_mont.sv
// Converts x into Montgomery form x*2^NBITS mod n by iterated doubling-reduce.
// Build option: RSA_XCEL_MONT_TO_MONT_RADIX4_EN chains two steps per cycle.
module rsa_xcel_mont_to_mont
   import rsa_xcel_mont_pkg::*;
#(
   parameter int unsigned NBITS = NBITS_DFLT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             istream_val,
   output logic             istream_rdy,
   input  logic [NBITS-1:0] istream_x,
   input  logic [NBITS-1:0] istream_n,
   output logic             ostream_val,
   input  logic             ostream_rdy,
   output logic [NBITS-1:0] ostream_msg
);

   logic [NBITS-1:0] r_q, r_d;
   logic [NBITS-1:0] n_q, n_d;
   logic [NBITS-1:0] msg_q, msg_d;
   logic [NBITS-1:0] step_r;
   logic             rdy_q, rdy_d;
   logic             val_q, val_d;
   state_t           state_q, state_d;

`ifdef RSA_XCEL_MONT_TO_MONT_RADIX4_EN
   localparam int unsigned STEPS = NBITS / 2;
   localparam int unsigned CNT_W = NBITS / 2;

   logic [NBITS-1:0] mid_r;

   rsa_xcel_mont_DblRed #(.NBITS(NBITS)) u_dbl0 (
      .r_in (r_q),
      .n    (n_q),
      .r_out(mid_r)
   );
   rsa_xcel_mont_DblRed #(.NBITS(NBITS)) u_dbl1 (
      .r_in (mid_r),
      .n    (n_q),
      .r_out(step_r)
   );
`else
   localparam int unsigned STEPS = NBITS;
   localparam int unsigned CNT_W = $clog2(NBITS) + 1;

   rsa_xcel_mont_DblRed #(.NBITS(NBITS)) u_dbl0 (
      .r_in (r_q),
      .n    (n_q),
      .r_out(step_r)
   );
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         r_q     <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         msg_q   <= '0;
         rdy_q   <= 1'b0;
         val_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         msg_q   <= msg_d;
         rdy_q   <= rdy_d;
         val_q   <= val_d;
      end
   end

   // Handshake flags are registered from the next state so they never overlap.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      msg_d   = msg_q;
      case (state_q)
         IDLE: begin
            if (istream_val && rdy_q) begin
               r_d     = istream_x;
               n_d     = istream_n;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            r_d   = step_r;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               msg_d   = step_r;
               state_d = DONE;
            end
         end
         DONE: begin
            if (ostream_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE);
      val_d = (state_d == DONE);
   end

   assign istream_rdy = rdy_q;
   assign ostream_val = val_q;
   assign ostream_msg = msg_q;

endmodule

// File: tb/tb_rsa_xcel_mont_to_mont.sv
// Directed and randomized checks of the Montgomery-form converter.
module tb_rsa_xcel_mont_to_mont;

   localparam int unsigned NB = 32;
`ifdef RSA_XCEL_MONT_TO_MONT_RADIX4_EN
   localparam int LAT = NB / 2 + 1;
`else
   localparam int LAT = NB + 1;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          istream_val = 1'b0;
   logic          istream_rdy;
   logic [NB-1:0] istream_x = '0;
   logic [NB-1:0] istream_n = '0;
   logic          ostream_val;
   logic          ostream_rdy = 1'b0;
   logic [NB-1:0] ostream_msg;

   int n_vec = 0;
   int n_err = 0;

   rsa_xcel_mont_to_mont #(.NBITS(NB)) dut (
      .clk        (clk),
      .reset      (reset),
      .istream_val(istream_val),
      .istream_rdy(istream_rdy),
      .istream_x  (istream_x),
      .istream_n  (istream_n),
      .ostream_val(ostream_val),
      .ostream_rdy(ostream_rdy),
      .ostream_msg(ostream_msg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive one request; returns just after the accept edge.
   task automatic send(input logic [NB-1:0] x, input logic [NB-1:0] n);
      int guard = 0;
      @(negedge clk);
      while (!istream_rdy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("rdy_before_req", 64'(istream_rdy), 64'd1);
      istream_val = 1'b1;
      istream_x   = x;
      istream_n   = n;
      @(posedge clk);
      #1;
      istream_val = 1'b0;
   endtask

   // Wait for the result, counting edges from the accept edge inclusive.
   task automatic wait_val(output logic [NB-1:0] msg, output int lat);
      lat = 1;
      while (!ostream_val && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      msg = ostream_msg;
   endtask

   task automatic take(input int delay);
      repeat (delay) @(negedge clk);
      @(negedge clk);
      ostream_rdy = 1'b1;
      @(posedge clk);
      #1;
      ostream_rdy = 1'b0;
      check("val_after_take", 64'(ostream_val), 64'd0);
      check("rdy_after_take", 64'(istream_rdy), 64'd1);
   endtask

   task automatic txn(input string tag, input logic [NB-1:0] x, input logic [NB-1:0] n,
                      input logic [NB-1:0] exp, input int delay);
      logic [NB-1:0] msg;
      int            lat;
      send(x, n);
      wait_val(msg, lat);
      check({tag, "_lat"}, 64'(lat), 64'(LAT));
      check(tag, 64'(msg), 64'(exp));
      take(delay);
   endtask

   initial begin
      logic [NB-1:0] msg;
      logic [NB-1:0] held;
      logic [NB-1:0] rx, rn;
      logic [63:0]   ref_v;
      int            lat;
      logic          saw;

      #12;
      check("rst_istream_rdy", 64'(istream_rdy), 64'd0);
      check("rst_ostream_val", 64'(ostream_val), 64'd0);
      check("rst_ostream_msg", 64'(ostream_msg), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("idle_rdy", 64'(istream_rdy), 64'd1);

      txn("basic_3_7", 32'd3, 32'd7, 32'd5, 0);
      txn("carry", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      txn("large_n", 32'd1, 32'hFFFF_FFFB, 32'd5, 0);
      txn("zero_13", 32'd0, 32'd13, 32'd0, 0);
      txn("zero_1", 32'd0, 32'd1, 32'd0, 0);

      // 5*2^32 mod 11: 2^32 = 4 mod 11, so 20 mod 11 = 9.
      send(32'd5, 32'd11);
      istream_val = 1'b1;
      istream_x   = 32'd1;
      istream_n   = 32'd3;
      saw = 1'b0;
      lat = 1;
      while (!ostream_val && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (istream_rdy) saw = 1'b1;
      end
      istream_val = 1'b0;
      check("no_accept_in_calc", 64'(saw), 64'd0);
      check("bp_lat", 64'(lat), 64'(LAT));
      held = ostream_msg;
      check("bp_msg", 64'(held), 64'd9);
      repeat (10) begin
         @(posedge clk);
         #1;
         check("bp_val_hold", 64'(ostream_val), 64'd1);
         check("bp_msg_hold", 64'(ostream_msg), 64'(held));
         check("bp_irdy_low", 64'(istream_rdy), 64'd0);
      end
      take(0);
      txn("after_bp", 32'd3, 32'd7, 32'd5, 0);

      // Asynchronous reset in the middle of a conversion.
      send(32'd3, 32'd7);
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_istream_rdy", 64'(istream_rdy), 64'd0);
      check("midrst_ostream_val", 64'(ostream_val), 64'd0);
      check("midrst_ostream_msg", 64'(ostream_msg), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("postrst_rdy", 64'(istream_rdy), 64'd1);
      saw = 1'b0;
      repeat (LAT + 5) begin
         @(posedge clk);
         #1;
         if (ostream_val) saw = 1'b1;
      end
      check("no_stale_val", 64'(saw), 64'd0);
      txn("postrst_3_7", 32'd3, 32'd7, 32'd5, 0);

      for (int i = 0; i < 1000; i++) begin
         rn = NB'($urandom) | NB'(1);
         rx = (rn == NB'(1)) ? '0 : NB'($urandom % rn);
         ref_v = ({32'd0, rx} << NB) % {32'd0, rn};
         send(rx, rn);
         wait_val(msg, lat);
         check("rand_lat", 64'(lat), 64'(LAT));
         check("rand_msg", 64'(msg), ref_v);
         take(int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
